// File: rtl/ast_ctrl.sv
// Threshold-triggered alert pulse controller: IDLE/ARMED/PULSE/HOLD sequencer with
// configurable pulse width and holdoff. Optional hit debounce with `define AST_DEBOUNCE_EN.
module ast_ctrl #(
  parameter int HOLDOFF = 16,
  parameter int DEB_N   = 3
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [15:0] ad_data,
  input  logic        ad_vld,
  input  logic [15:0] cfg_thr,
  input  logic [7:0]  cfg_pol,
  input  logic [7:0]  cfg_width,
  input  logic [7:0]  cmd_ast,
  input  logic        cmd_vld,
  output logic        ast,
  output logic [7:0]  stu_sensor
);

  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, PULSE = 2'b10, HOLD = 2'b11} state_t;

  if (HOLDOFF < 1 || HOLDOFF > 255) begin : g_bad_holdoff
    $error("ast_ctrl: HOLDOFF out of range 1..255");
  end
  if (DEB_N < 1 || DEB_N > 15) begin : g_bad_deb_n
    $error("ast_ctrl: DEB_N out of range 1..15");
  end

  state_t      state, state_nxt;
  logic [7:0]  wcnt, hcnt;
  logic [4:0]  trig_cnt;
  logic        last_cmp;
  logic        ast_nxt;
  logic        hit, trig, pulse_entry;
  logic        cmd_arm, cmd_disarm, cmd_force;
  logic        unused;

  assign cmd_arm     = cmd_vld & cmd_ast[0];
  assign cmd_disarm  = cmd_vld & cmd_ast[1];
  assign cmd_force   = cmd_vld & cmd_ast[2];
  assign unused      = ^{cfg_pol[7:2], cmd_ast[7:3]};

  // Strict compare both ways, so ad_data == cfg_thr never hits.
  assign hit = cfg_pol[1] ? (ad_data < cfg_thr) : (ad_data > cfg_thr);

`ifdef AST_DEBOUNCE_EN
  logic [3:0] deb_cnt;
  logic       deb_done;

  assign deb_done = (deb_cnt == 4'(DEB_N - 1));
  assign trig     = ad_vld & hit & deb_done;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst)                                         deb_cnt <= '0;
    else if (state != ARMED || state_nxt != ARMED)   deb_cnt <= '0;
    else if (ad_vld)                                 deb_cnt <= hit ? deb_cnt + 4'd1 : 4'd0;
  end
`else
  assign trig = ad_vld & hit;
`endif

  // State register
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ast   <= 1'b0;
    end else begin
      state <= state_nxt;
      ast   <= ast_nxt;
    end
  end

  // Next-state logic; DISARM overrides everything
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (cmd_force) state_nxt = PULSE;
             else if (cmd_arm) state_nxt = ARMED;
      ARMED: if (cmd_force || trig) state_nxt = PULSE;
      PULSE: if (wcnt == 8'd0) state_nxt = HOLD;
      HOLD:  if (hcnt == 8'd0) state_nxt = ARMED;
    endcase
    if (cmd_disarm) state_nxt = IDLE;
  end

  // Output logic: disarm drops the pulse on the same edge the state leaves PULSE
  always_comb begin
    ast_nxt = ~cfg_pol[0];
    if (state == PULSE && !cmd_disarm) ast_nxt = cfg_pol[0];
  end

  assign pulse_entry = (state != PULSE) && (state_nxt == PULSE);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      wcnt     <= '0;
      hcnt     <= '0;
      trig_cnt <= '0;
      last_cmp <= 1'b0;
    end else begin
      if (cmd_disarm) begin
        wcnt <= '0;
        hcnt <= '0;
      end else begin
        // Counters hold "cycles remaining minus one" so exit fires on zero
        if (pulse_entry)
          wcnt <= (cfg_width == 8'd0) ? 8'd0 : cfg_width - 8'd1;
        else if (state == PULSE && wcnt != 8'd0)
          wcnt <= wcnt - 8'd1;
        if (state == PULSE && state_nxt == HOLD)
          hcnt <= 8'(HOLDOFF - 1);
        else if (state == HOLD && hcnt != 8'd0)
          hcnt <= hcnt - 8'd1;
      end
      if (pulse_entry && trig_cnt != 5'd31) trig_cnt <= trig_cnt + 5'd1;
      if (ad_vld) last_cmp <= hit;
    end
  end

  assign stu_sensor = {trig_cnt, last_cmp, state};

endmodule

// File: tb/tb_ast_ctrl.sv
// Self-checking bench for ast_ctrl: compare table, directed corner sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_ast_ctrl;
  localparam int HOLDOFF = 16;
  localparam int DEB_N   = 3;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [15:0] ad_data, cfg_thr;
  logic        ad_vld, cmd_vld;
  logic [7:0]  cfg_pol, cfg_width, cmd_ast;
  logic        ast;
  logic [7:0]  stu_sensor;

  ast_ctrl #(.HOLDOFF(HOLDOFF), .DEB_N(DEB_N)) dut (
    .clk_sys(clk_sys), .rst(rst), .ad_data(ad_data), .ad_vld(ad_vld),
    .cfg_thr(cfg_thr), .cfg_pol(cfg_pol), .cfg_width(cfg_width),
    .cmd_ast(cmd_ast), .cmd_vld(cmd_vld), .ast(ast), .stu_sensor(stu_sensor)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_pass = 0;

  // Model: mode 0 idle, 1 armed, 2 pulsing, 3 holding off (codes match stu_sensor[1:0])
  int m_st, m_pl, m_hl, m_run, m_trig;
  bit m_last, m_ast;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_st = 0; m_pl = 0; m_hl = 0; m_run = 0; m_trig = 0; m_last = 0; m_ast = 0;
  endtask

  task automatic model_step();
    bit dis, arm, frc, h, go;
    int w;
    dis = cmd_vld && cmd_ast[1];
    arm = cmd_vld && cmd_ast[0];
    frc = cmd_vld && cmd_ast[2];
    h   = cfg_pol[1] ? (ad_data < cfg_thr) : (ad_data > cfg_thr);
    w   = (cfg_width == 0) ? 1 : int'(cfg_width);
    go  = 0;
    m_ast = (m_st == 2 && !dis) ? cfg_pol[0] : !cfg_pol[0];
    if (ad_vld) m_last = h;
    if (dis) begin
      m_st = 0; m_run = 0;
    end else begin
      case (m_st)
        0: if (frc) go = 1; else if (arm) m_st = 1;
        1: begin
`ifdef AST_DEBOUNCE_EN
          if (ad_vld) m_run = h ? m_run + 1 : 0;
          if (m_run >= DEB_N) go = 1;
`else
          if (ad_vld && h) go = 1;
`endif
          if (frc) go = 1;
        end
        2: begin
          m_pl--;
          if (m_pl == 0) begin m_st = 3; m_hl = HOLDOFF; end
        end
        default: begin
          m_hl--;
          if (m_hl == 0) m_st = 1;
        end
      endcase
    end
    if (go) begin
      m_st = 2; m_pl = w; m_run = 0;
      m_trig = (m_trig < 31) ? m_trig + 1 : 31;
    end
  endtask

  task automatic cyc();
    logic [7:0] exp_stu;
    @(posedge clk_sys);
    model_step();
    @(negedge clk_sys);
    exp_stu = {5'(m_trig), m_last, 2'(m_st)};
    chk("ast_model", 8'(ast), 8'(m_ast));
    chk("stu_model", stu_sensor, exp_stu);
  endtask

  task automatic samp(input logic [15:0] d);
    ad_data = d; ad_vld = 1'b1;
    cyc();
    ad_vld = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] c);
    cmd_ast = c; cmd_vld = 1'b1;
    cyc();
    cmd_vld = 1'b0; cmd_ast = 8'h00;
  endtask

  typedef struct {
    logic [15:0] d;
    logic [15:0] thr;
    logic [7:0]  pol;
    logic        exp_hit;
  } vec_t;

  initial begin
    vec_t tv[8];
    int na, nh;

    tv[0] = '{16'd1500,  16'd1000,  8'h00, 1'b1};
    tv[1] = '{16'd1000,  16'd1000,  8'h00, 1'b0};
    tv[2] = '{16'd1001,  16'd1000,  8'h01, 1'b1};
    tv[3] = '{16'd999,   16'd1000,  8'h02, 1'b1};
    tv[4] = '{16'd1000,  16'd1000,  8'h02, 1'b0};
    tv[5] = '{16'd0,     16'd0,     8'h03, 1'b0};
    tv[6] = '{16'd65535, 16'd65534, 8'h00, 1'b1};
    tv[7] = '{16'd5,     16'd6,     8'hFE, 1'b1};

    rst = 1'b1; ad_data = '0; ad_vld = 0; cfg_thr = 16'd1000; cfg_pol = 8'h01;
    cfg_width = 8'd4; cmd_ast = '0; cmd_vld = 0;
    model_reset();
    #2;
    chk("rst_ast", 8'(ast), 8'h00);
    chk("rst_stu", stu_sensor, 8'h00);
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_hold_stu", stu_sensor, 8'h00);
    rst = 1'b0;

    // Raw compare flag in IDLE, across both directions and the equality boundary
    foreach (tv[i]) begin
      cfg_thr = tv[i].thr; cfg_pol = tv[i].pol;
      samp(tv[i].d);
      chk("cmp_tbl", 8'(stu_sensor[2]), 8'(tv[i].exp_hit));
    end
    chk("tbl_still_idle", 8'(stu_sensor[1:0]), 8'h00);

    // Armed hit: 4-cycle pulse one edge after the sample, then 16 cycles of holdoff
    cfg_thr = 16'd1000; cfg_pol = 8'h01; cfg_width = 8'd4;
    cmd(8'h01);
    chk("armed", 8'(stu_sensor[1:0]), 8'h01);
    samp(16'd1500);
    chk("hit_lat_ast", 8'(ast), 8'h00);
    chk("hit_state", 8'(stu_sensor[1:0]), 8'h02);
    na = 0; nh = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (i == 0) chk("hit_first_ast", 8'(ast), 8'h01);
      if (ast == 1'b1) na++;
      if (stu_sensor[1:0] == 2'b11) nh++;
    end
    chk("pulse_len4", 8'(na), 8'd4);
    chk("hold_len16", 8'(nh), 8'd16);
    chk("trig_cnt1", 8'(stu_sensor[7:3]), 8'd1);
    chk("rearmed", 8'(stu_sensor[1:0]), 8'h01);

    // Active-low, below-threshold: 999 triggers, 1000 does not
    cfg_pol = 8'h02;
    cyc();
    samp(16'd999);
    na = 0;
    for (int i = 0; i < 30; i++) begin cyc(); if (ast == 1'b0) na++; end
    chk("low_pulse_len", 8'(na), 8'd4);
    samp(16'd1000);
    na = 0;
    for (int i = 0; i < 30; i++) begin cyc(); if (ast == 1'b0) na++; end
    chk("eq_no_trig", 8'(na), 8'd0);
    chk("eq_trig_cnt", 8'(stu_sensor[7:3]), 8'd2);

    // Width 0 -> 1 cycle; width change mid-pulse is ignored
    cfg_pol = 8'h01; cfg_width = 8'd0;
    samp(16'd1500);
    na = 0;
    for (int i = 0; i < 30; i++) begin cyc(); if (ast) na++; end
    chk("width0_len", 8'(na), 8'd1);
    cfg_width = 8'd3;
    samp(16'd1500);
    na = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (i == 0) cfg_width = 8'd10;
      if (ast) na++;
    end
    chk("width_latched", 8'(na), 8'd3);

    // ARM|DISARM while armed -> idle; DISARM mid-pulse drops ast on the same edge
    cmd(8'h03);
    chk("arm_disarm_idle", 8'(stu_sensor[1:0]), 8'h00);
    cmd(8'h04);
    cyc(); cyc();
    chk("force_pulse_ast", 8'(ast), 8'h01);
    cmd(8'h02);
    chk("disarm_ast", 8'(ast), 8'h00);
    chk("disarm_state", 8'(stu_sensor[1:0]), 8'h00);

    // Trigger count saturates at 31
    cfg_width = 8'd1;
    for (int i = 0; i < 40; i++) begin cmd(8'h04); cmd(8'h02); end
    chk("trig_sat", 8'(stu_sensor[7:3]), 8'd31);

`ifdef AST_DEBOUNCE_EN
    cmd(8'h01);
    samp(16'd1500); samp(16'd1500); samp(16'd500);
    samp(16'd1500); samp(16'd1500);
    chk("deb_not_yet", 8'(stu_sensor[1:0]), 8'h01);
    samp(16'd1500);
    chk("deb_trig6", 8'(stu_sensor[1:0]), 8'h02);
`else
    cmd(8'h01);
    samp(16'd1500);
    chk("single_hit_trig", 8'(stu_sensor[1:0]), 8'h02);
`endif
    cmd(8'h02);

    // Asynchronous reset mid-pulse, then ast tracks ~cfg_pol[0] from the first edge
    cfg_width = 8'd10;
    cmd(8'h04);
    cyc(); cyc();
    rst = 1'b1;
    #1;
    chk("async_rst_ast", 8'(ast), 8'h00);
    chk("async_rst_stu", stu_sensor, 8'h00);
    model_reset();
    cfg_pol = 8'h00;
    @(posedge clk_sys);
    @(negedge clk_sys);
    rst = 1'b0;
    cyc();
    chk("post_rst_ast", 8'(ast), 8'h01);

    // Randomized traffic against the model
    cfg_pol = 8'h01; cfg_thr = 16'd30000;
    for (int i = 0; i < 3000; i++) begin
      ad_vld = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 40) == 0) cfg_thr = 16'($urandom_range(2, 65533));
      ad_data = 16'(int'(cfg_thr) + int'($urandom_range(0, 4)) - 2);
      if ($urandom_range(0, 50) == 0) cfg_pol = 8'($urandom);
      if ($urandom_range(0, 20) == 0) cfg_width = 8'($urandom_range(0, 5));
      cmd_vld = ($urandom_range(0, 11) == 0);
      cmd_ast = 8'($urandom);
      if ($urandom_range(0, 3) != 0) cmd_ast[1] = 1'b0;
      cyc();
    end
    ad_vld = 0; cmd_vld = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ast_ctrl.md
AST_CTRL -- requirements
Module: ast_ctrl

Interface
REQ-001 Parameter HOLDOFF, default 16: clk_sys cycles spent in HOLD after each pulse, range 1..255.
REQ-002 Parameter DEB_N, default 3: consecutive hit samples required when AST_DEBOUNCE_EN is defined, range 1..15.
REQ-003 clk_sys  input  1  single system clock; all logic rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ad_data  input  16  unsigned ADC sample.
REQ-006 ad_vld  input  1  one-cycle strobe, ad_data valid.
REQ-007 cfg_thr  input  16  unsigned trigger threshold.
REQ-008 cfg_pol  input  8  bit0 ast active level (1=high); bit1 compare direction (0: ad_data>cfg_thr, 1: ad_data<cfg_thr); bits7:2 ignored.
REQ-009 cfg_width  input  8  ast pulse width in clk_sys cycles; 0 treated as 1.
REQ-010 cmd_ast  input  8  bit0 ARM, bit1 DISARM, bit2 FORCE; bits7:3 ignored; sampled only when cmd_vld=1.
REQ-011 cmd_vld  input  1  one-cycle command strobe.
REQ-012 ast  output  1  registered alert pulse.
REQ-013 stu_sensor  output  8  [1:0] state code, [2] last compare result, [7:3] trigger count.

Function
REQ-014 FSM states and codes: IDLE=00, ARMED=01, PULSE=10, HOLD=11.
REQ-015 IDLE->ARMED on cmd_vld with ARM set; ARM in any other state ignored.
REQ-016 ARMED->PULSE in the cycle after ad_vld=1 with hit condition met (debounce per REQ-030/031).
REQ-017 IDLE or ARMED->PULSE in the cycle after cmd_vld with FORCE set; FORCE ignored in PULSE/HOLD.
REQ-018 cfg_width latched on PULSE entry; mid-pulse changes have no effect on the current pulse.
REQ-019 PULSE lasts exactly max(cfg_width,1) cycles, then ->HOLD.
REQ-020 HOLD lasts exactly HOLDOFF cycles, ad_vld ignored, then ->ARMED.
REQ-021 DISARM in any state ->IDLE next cycle, ast returns inactive the same edge, counters cleared; DISARM beats ARM/FORCE in the same command.
REQ-022 ast = cfg_pol[0] while in PULSE, else ~cfg_pol[0]; registered, one cycle after state change.
REQ-023 Hit latency: ad_vld sample at edge N -> ast active from edge N+1 (no debounce).
REQ-024 stu_sensor[2] updates on every ad_vld with the raw compare result, in all states.
REQ-025 Trigger count increments on each PULSE entry (hit or FORCE), saturates at 31, never wraps; cleared only by reset.
REQ-026 ad_data equal to cfg_thr is never a hit in either direction.
REQ-027 cfg_pol/cfg_thr are used combinationally at compare time; no latching.

Reset
REQ-028 While rst=1: state=IDLE, ast=0, stu_sensor=8'h00, width/holdoff/debounce counters=0.
REQ-029 After rst release, ast drives ~cfg_pol[0] from the first clk_sys edge; rst mid-pulse truncates the pulse immediately (asynchronous).

Configuration
REQ-030 Macro AST_DEBOUNCE_EN defined: ARMED->PULSE requires DEB_N consecutive ad_vld samples that hit; a non-hit sample resets the run count; count cleared on leaving ARMED.
REQ-031 AST_DEBOUNCE_EN undefined: a single hit sample triggers; no debounce counter is instantiated and DEB_N is unused.

Verification
REQ-032 Reset, then ARM, cfg_thr=1000, cfg_pol=0x01, cfg_width=4, one ad_vld with ad_data=1500 -> ast high for exactly 4 cycles starting next edge, stu_sensor[7:3]=1, then HOLD for 16 cycles.
REQ-033 cfg_pol=0x02 (active low, below), ad_data=999 then 1000 -> 999 triggers ast low; 1000 after rearm never triggers.
REQ-034 cfg_width=0 -> 1-cycle pulse; cfg_width changed 3->10 mid-pulse -> pulse stays 3 cycles.
REQ-035 cmd_ast=0x03 while ARMED -> IDLE; DISARM during PULSE -> ast inactive next edge, state code 00.
REQ-036 40 FORCE/rearm cycles -> trigger count reads 31; with AST_DEBOUNCE_EN, DEB_N=3, hit-hit-miss-hit-hit-hit -> trigger after the 6th sample only.
